// File: rtl/scan_seq_pkg.sv
// Shared types and defaults for the scan select sequencer and its step debouncer.
package scan_seq_pkg;

  localparam int SEL_W               = 2;
  localparam int DEF_DWELL_BASE      = 16;
  localparam int DEF_BLANK_CYCLES    = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_CNT_W           = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_BLANK = 2'd2
  } state_e;

  // Next decoder select; 3 wraps back to 0.
  function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] sel);
    return sel + 1'b1;
  endfunction

endpackage

// File: rtl/step_debouncer.sv
// Pushbutton conditioner: 2-flop synchronizer, stable-sample debounce and a
// one-cycle pulse on each accepted 0->1 change of the debounced level.
module step_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic rise_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;

  // The level flips on the edge that sees the last of DEBOUNCE_CYCLES
  // consecutive synchronized samples disagreeing with it.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    level_d = level_q;
    cnt_d   = cnt_q;
    accept  = (sync2_q != level_q) && (cnt_q == CNT_LAST);
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (accept) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pulse is decoded from flop outputs only, so it lines up with the edge
  // that updates the debounced level.
  assign rise_o = accept && sync2_q;

endmodule

// File: rtl/scan_select_sequencer.sv
// Drives select and active-low enable of a 2-to-4 decoder: timed auto scan with
// blanking between selections, or manual single-step from a debounced button.
module scan_select_sequencer
  import scan_seq_pkg::*;
#(
  parameter int DWELL_BASE      = DEF_DWELL_BASE,
  parameter int BLANK_CYCLES    = DEF_BLANK_CYCLES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_i,
  input  logic       auto_i,
  input  logic       step_in,
  input  logic [1:0] dwell_sel_i,
  output logic [1:0] sel_o,
  output logic       en_n_o,
  output logic       frame_o,
  output logic [1:0] state_o
);

  localparam logic [CNT_W-1:0] DWELL_BASE_W = CNT_W'(DWELL_BASE);
  localparam logic [CNT_W-1:0] BLANK_LAST   = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic                 en_n_q, en_n_d;
  logic                 frame_q, frame_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     dwell_len_q, dwell_len_d;
  logic                 auto_q, auto_d;

  logic                 step_evt;
  logic                 step_ok;
  logic                 phase_end;
  logic                 drive_entry;

  step_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_step_debouncer (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (step_in),
    .rise_o (step_evt)
  );

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    dwell_len_d = dwell_len_q;
    auto_d      = auto_i;
    phase_end   = 1'b0;
    drive_entry = 1'b0;
    // Step events outside a manual DRIVE are simply dropped.
    step_ok     = step_evt && (state_q == ST_DRIVE) && !auto_i;

    if (!run_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: drive_entry = 1'b1;
        ST_DRIVE: begin
          if (auto_i && !auto_q) begin
            cnt_d = '0;
          end else if (auto_i) begin
            if (cnt_q == dwell_len_q - 1'b1) phase_end = 1'b1;
            else                             cnt_d     = cnt_q + 1'b1;
          end else if (step_ok) begin
            phase_end = 1'b1;
          end
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            sel_d       = next_sel(sel_q);
            drive_entry = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase

      // With no blanking the next selection starts on the same edge.
      if (phase_end) begin
        if (BLANK_CYCLES == 0) begin
          sel_d       = next_sel(sel_q);
          drive_entry = 1'b1;
        end else begin
          state_d = ST_BLANK;
          cnt_d   = '0;
        end
      end

      if (drive_entry) begin
        state_d     = ST_DRIVE;
        cnt_d       = '0;
        dwell_len_d = DWELL_BASE_W << dwell_sel_i;
      end
    end

    en_n_d  = (state_d != ST_DRIVE);
    frame_d = drive_entry && (sel_d == '0) && auto_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      en_n_q      <= 1'b1;
      frame_q     <= 1'b0;
      cnt_q       <= '0;
      dwell_len_q <= '0;
      auto_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      en_n_q      <= en_n_d;
      frame_q     <= frame_d;
      cnt_q       <= cnt_d;
      dwell_len_q <= dwell_len_d;
      auto_q      <= auto_d;
    end
  end

  assign sel_o   = sel_q;
  assign en_n_o  = en_n_q;
  assign frame_o = frame_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_scan_select_sequencer.sv
// Bench for scan_select_sequencer: one instance with blanking, one without,
// both compared every cycle against a phase/remaining-cycles model.
module tb_scan_select_sequencer;

  localparam int DB = 4;
  localparam int BC = 2;
  localparam int DC = 3;

  logic       clk = 1'b0;
  logic       rst_n, run_i, auto_i, step_in;
  logic [1:0] dwell_sel_i;
  logic [1:0] sel_a, state_a, sel_b, state_b;
  logic       en_a, fr_a, en_b, fr_b;

  always #5 clk = ~clk;

  scan_select_sequencer #(
    .DWELL_BASE(DB), .BLANK_CYCLES(BC), .DEBOUNCE_CYCLES(DC), .CNT_W(20)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .run_i(run_i), .auto_i(auto_i), .step_in(step_in),
    .dwell_sel_i(dwell_sel_i), .sel_o(sel_a), .en_n_o(en_a), .frame_o(fr_a), .state_o(state_a)
  );

  scan_select_sequencer #(
    .DWELL_BASE(DB), .BLANK_CYCLES(0), .DEBOUNCE_CYCLES(DC), .CNT_W(20)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .run_i(run_i), .auto_i(auto_i), .step_in(step_in),
    .dwell_sel_i(dwell_sel_i), .sel_o(sel_b), .en_n_o(en_b), .frame_o(fr_b), .state_o(state_b)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0=idle 1=drive 2=blank, remain = cycles left in the current phase.
  typedef struct {
    int mode;
    int sel;
    int remain;
    int dwell;
    bit frame;
  } mdl_t;

  function automatic mdl_t enter_drive(mdl_t m, int s, bit au, int ds);
    mdl_t n = m;
    n.mode   = 1;
    n.sel    = s % 4;
    n.dwell  = DB << ds;
    n.remain = n.dwell;
    n.frame  = (n.sel == 0) && au;
    return n;
  endfunction

  function automatic mdl_t mdl_next(mdl_t m, int blank, bit run, bit au, bit au_prev, bit evt, int ds);
    mdl_t n = m;
    n.frame = 1'b0;
    if (!run) begin
      n.mode = 0;
      return n;
    end
    case (m.mode)
      0: n = enter_drive(m, m.sel, au, ds);
      1: begin
        if (au && !au_prev) n.remain = m.dwell;
        else if ((au && m.remain == 1) || (!au && evt)) begin
          if (blank == 0) n = enter_drive(m, m.sel + 1, au, ds);
          else begin
            n.mode   = 2;
            n.remain = blank;
          end
        end else if (au) n.remain = m.remain - 1;
      end
      2: begin
        if (m.remain == 1) n = enter_drive(m, m.sel + 1, au, ds);
        else               n.remain = m.remain - 1;
      end
      default: n.mode = 0;
    endcase
    return n;
  endfunction

  mdl_t ma, mb;
  bit   hist [DC+2];
  bit   lvl, auto_prev, evt, all_diff;

  initial begin : compare
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        ma = '{0, 0, 0, 0, 1'b0};
        mb = '{0, 0, 0, 0, 1'b0};
        for (int k = 0; k < DC + 2; k++) hist[k] = 1'b0;
        lvl       = 1'b0;
        auto_prev = 1'b0;
      end else begin
        for (int k = DC + 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = step_in;
        // Debounced level follows the raw input once DC samples, seen two
        // synchronizer stages late, all disagree with it.
        all_diff = 1'b1;
        for (int k = 2; k <= DC + 1; k++) if (hist[k] == lvl) all_diff = 1'b0;
        evt = 1'b0;
        if (all_diff) begin
          evt = !lvl;
          lvl = !lvl;
        end
        ma = mdl_next(ma, BC, run_i, auto_i, auto_prev, evt, int'(dwell_sel_i));
        mb = mdl_next(mb, 0,  run_i, auto_i, auto_prev, evt, int'(dwell_sel_i));
        auto_prev = auto_i;
      end
      #1;
      check("cmp sel_a",   sel_a,   ma.sel);
      check("cmp en_a",    en_a,    ma.mode != 1);
      check("cmp frame_a", fr_a,    ma.frame);
      check("cmp state_a", state_a, ma.mode);
      check("cmp sel_b",   sel_b,   mb.sel);
      check("cmp en_b",    en_b,    mb.mode != 1);
      check("cmp frame_b", fr_b,    mb.frame);
      check("cmp state_b", state_b, mb.mode);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits for dut_a's enable to go low, then counts its low cycles.
  task automatic measure_low(output int len, output int first_sel);
    int guard = 0;
    len = 0;
    first_sel = -1;
    while (en_a !== 1'b0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (en_a !== 1'b0) begin
      check("measure_low start timeout", guard, 0);
      return;
    end
    first_sel = int'(sel_a);
    while (en_a === 1'b0 && len < 200) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic wait_a(input int want_sel, input int want_state, input string name);
    int guard = 0;
    while (!((want_sel < 0 || int'(sel_a) == want_sel) && int'(state_a) == want_state) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) check(name, guard, 0);
  endtask

  int len, s0, k;

  initial begin : stimulus
    rst_n = 1'b0; run_i = 1'b0; auto_i = 1'b0; step_in = 1'b0; dwell_sel_i = 2'd0;
    cyc(2);
    check("reset sel",   sel_a,   0);
    check("reset en_n",  en_a,    1);
    check("reset frame", fr_a,    0);
    check("reset state", state_a, 0);

    // Auto scan: 4 low + 2 blank per selection; the no-blank copy steps every 4.
    run_i = 1'b1; auto_i = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("scan sel_a",   sel_a, (i / 6) % 4);
      check("scan en_a",    en_a,  (i % 6) >= 4);
      check("scan frame_a", fr_a,  (i % 24) == 0);
      check("noblank sel_b",   sel_b, (i / 4) % 4);
      check("noblank en_b",    en_b,  0);
      check("noblank frame_b", fr_b,  (i % 16) == 0);
    end

    // Dwell change mid-DRIVE applies only to the following DRIVE.
    fork
      measure_low(len, s0);
      begin
        cyc(2);
        dwell_sel_i = 2'd2;
      end
    join
    check("dwell current", len, 4);
    measure_low(len, s0);
    check("dwell next",     len, 16);
    check("dwell next sel", s0,  2);
    dwell_sel_i = 2'd0;

    // Park while sel=2 is driven, then resume with a full dwell on sel=2.
    wait_a(2, 1, "wait sel2 drive timeout");
    run_i = 1'b0;
    @(negedge clk);
    check("park en_n",  en_a,    1);
    check("park sel",   sel_a,   2);
    check("park state", state_a, 0);
    cyc(3);
    check("park sel held", sel_a, 2);
    run_i = 1'b1;
    measure_low(len, s0);
    check("resume dwell", len, 4);
    check("resume sel",   s0,  2);

    // Manual step: glitches ignored, one advance 5 cycles after a stable rise.
    wait_a(-1, 1, "wait drive timeout");
    auto_i = 1'b0;
    s0 = int'(sel_a);
    repeat (3) begin
      step_in = 1'b1;
      cyc(1);
      step_in = 1'b0;
      cyc(2);
    end
    check("glitch sel",  sel_a, s0);
    check("glitch en_n", en_a,  0);
    step_in = 1'b1;
    k = 0;
    while (en_a === 1'b0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("step latency", k, 5);
    if (k < 10) cyc(10 - k);
    step_in = 1'b0;
    cyc(12);
    check("step one advance", sel_a, (s0 + 1) % 4);
    check("step holds drive", en_a,  0);

    // Asynchronous reset in the middle of BLANK.
    auto_i = 1'b1;
    wait_a(-1, 2, "wait blank timeout");
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst sel_a",   sel_a,   0);
    check("async rst en_a",    en_a,    1);
    check("async rst state_a", state_a, 0);
    check("async rst frame_a", fr_a,    0);
    check("async rst sel_b",   sel_b,   0);
    check("async rst en_b",    en_b,    1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post rst en_n",  en_a,    0);
    check("post rst sel",   sel_a,   0);
    check("post rst frame", fr_a,    1);
    check("post rst state", state_a, 1);

    // Random mix of park, mode, dwell, button noise and occasional reset.
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 499) != 0);
      run_i = ($urandom_range(0, 99) < 96);
      if ($urandom_range(0, 29) == 0) auto_i = ~auto_i;
      if ($urandom_range(0, 39) == 0) dwell_sel_i = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 5) == 0) step_in = ~step_in;
    end
    rst_n = 1'b1;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
